// File: rtl/bkram_pkg.sv
// Shared types and helpers for the backup-RAM transfer sequencer.
package bkram_pkg;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    localparam int SECTOR_BYTES = 512;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered-history edge detector: rise/fall are combinational from d and the
// previous-cycle value, so an edge is visible in the same cycle d changes.
module edge_det (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk_sys) begin
        if (reset) prev <= 1'b0;
        else       prev <= d;
    end

    assign rise = d & ~prev;
    assign fall = ~d & prev;

endmodule

// File: rtl/bkram_ctrl.sv
// Backup-RAM sequencer: sector-by-sector load/save between NVRAM and SD image.
// Request edge -> sd_rd/sd_wr in 1 cycle; requests while busy are dropped.
module bkram_ctrl
    import bkram_pkg::*;
#(
    parameter int          SECTORS     = 64,
    parameter logic [23:0] ACK_TIMEOUT = 24'd12_000_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cart_download,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_nz,
    input  logic        osd_status,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        autosave_en,
    input  logic        nvram_we,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_busy,
    output logic        bk_loading,
    output logic        bk_pending,
    output logic        bk_error
);

    localparam int LW = (clog2(SECTORS) > 0) ? clog2(SECTORS) : 1;

    state_t        state, state_nx;
    logic [LW-1:0] lba, lba_nx;
    logic [23:0]   timer, timer_nx;
    logic          rd_q, rd_nx, wr_q, wr_nx;
    logic          busy_q, busy_nx, loading_q, loading_nx, error_q, error_nx;
    logic          ena_q, pending_q;

    logic load_rise, load_fall, save_rise, save_fall, auto_rise, auto_fall;
    logic dl_rise, dl_fall, ack_rise, ack_fall;
    logic auto_trig, start_load, start_save, last_sector, timed_out;

    assign auto_trig = pending_q & osd_status & autosave_en;

    edge_det u_load (.clk_sys(clk_sys), .reset(reset), .d(load_req & ena_q),
                     .rise(load_rise), .fall(load_fall));
    edge_det u_save (.clk_sys(clk_sys), .reset(reset), .d(save_req & ena_q),
                     .rise(save_rise), .fall(save_fall));
    edge_det u_auto (.clk_sys(clk_sys), .reset(reset), .d(auto_trig & ena_q),
                     .rise(auto_rise), .fall(auto_fall));
    edge_det u_dl   (.clk_sys(clk_sys), .reset(reset), .d(cart_download),
                     .rise(dl_rise), .fall(dl_fall));
    edge_det u_ack  (.clk_sys(clk_sys), .reset(reset), .d(sd_ack),
                     .rise(ack_rise), .fall(ack_fall));

    logic unused_edges;
    assign unused_edges = ^{load_fall, save_fall, auto_fall};

    assign start_load  = load_rise | (dl_fall & img_size_nz & ena_q);
    assign start_save  = save_rise | auto_rise;
    assign last_sector = (lba == LW'(SECTORS - 1));
    assign timed_out   = (ACK_TIMEOUT != 24'd0) && (timer == ACK_TIMEOUT - 24'd1);

    always_comb begin
        state_nx   = state;
        lba_nx     = lba;
        rd_nx      = rd_q;
        wr_nx      = wr_q;
        busy_nx    = busy_q;
        loading_nx = loading_q;
        error_nx   = error_q;
        case (state)
            IDLE: begin
                // Load outranks save; a coincident save edge is simply lost.
                if (start_load | start_save) begin
                    state_nx   = REQ;
                    lba_nx     = '0;
                    busy_nx    = 1'b1;
                    loading_nx = start_load;
                    error_nx   = 1'b0;
                    rd_nx      = start_load;
                    wr_nx      = ~start_load;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    state_nx = XFER;
                end else if (timed_out) begin
                    state_nx   = IDLE;
                    rd_nx      = 1'b0;
                    wr_nx      = 1'b0;
                    busy_nx    = 1'b0;
                    loading_nx = 1'b0;
                    error_nx   = 1'b1;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    if (last_sector) begin
                        state_nx   = IDLE;
                        busy_nx    = 1'b0;
                        loading_nx = 1'b0;
                    end else begin
                        state_nx = REQ;
                        lba_nx   = lba + 1'b1;
                        rd_nx    = loading_q;
                        wr_nx    = ~loading_q;
                    end
                end else if (timed_out) begin
                    state_nx   = IDLE;
                    busy_nx    = 1'b0;
                    loading_nx = 1'b0;
                    error_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Restart the watchdog on every state entry.
        timer_nx = (state_nx != state || state == IDLE) ? 24'd0 : timer + 24'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            lba       <= '0;
            timer     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            error_q   <= 1'b0;
            ena_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state     <= state_nx;
            lba       <= lba_nx;
            timer     <= timer_nx;
            rd_q      <= rd_nx;
            wr_q      <= wr_nx;
            busy_q    <= busy_nx;
            loading_q <= loading_nx;
            error_q   <= error_nx;
            if (cart_download & img_mounted & ~img_readonly) ena_q <= 1'b1;
            else if (dl_rise)                                ena_q <= 1'b0;
            if (ena_q & ~osd_status & nvram_we) pending_q <= 1'b1;
            else if (busy_q)                    pending_q <= 1'b0;
        end
    end

    assign sd_lba     = 32'(lba);
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = ena_q;
    assign bk_busy    = busy_q;
    assign bk_loading = loading_q;
    assign bk_pending = pending_q;
    assign bk_error   = error_q;

endmodule

// File: tb/tb_bkram_ctrl.sv
// Scoreboard bench for bkram_ctrl with a simple hps_io acknowledge responder.
module tb_bkram_ctrl;

    localparam int NSEC = 64;
    localparam logic [1:0] DIR_RD = 2'b10;
    localparam logic [1:0] DIR_WR = 2'b01;

    logic        clk_sys = 1'b0;
    logic        reset, cart_download, img_mounted, img_readonly, img_size_nz;
    logic        osd_status, load_req, save_req, autosave_en, nvram_we, sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_busy, bk_loading, bk_pending, bk_error;

    typedef struct {
        logic [1:0]  dir;
        logic [31:0] lba;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    bit   ack_en = 1'b1;

    always #5 clk_sys = ~clk_sys;

    bkram_ctrl #(.SECTORS(NSEC), .ACK_TIMEOUT(24'd100)) dut (
        .clk_sys(clk_sys), .reset(reset), .cart_download(cart_download),
        .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size_nz(img_size_nz), .osd_status(osd_status), .load_req(load_req),
        .save_req(save_req), .autosave_en(autosave_en), .nvram_we(nvram_we),
        .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_loading(bk_loading),
        .bk_pending(bk_pending), .bk_error(bk_error)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_xfer(input logic [1:0] dir);
        exp_t e;
        for (int i = 0; i < NSEC; i++) begin
            e.dir = dir;
            e.lba = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            step();
            if (!bk_busy) done = 1'b1;
        end
        check_val(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_lba"}, sd_lba, 32'd0);
        check_val({tag, "_rdwr"}, {30'd0, sd_rd, sd_wr}, 32'd0);
        check_val({tag, "_flags"}, {27'd0, bk_ena, bk_busy, bk_loading, bk_pending, bk_error}, 32'd0);
    endtask

    // hps_io model: every request is matched against the scoreboard head.
    always begin : responder
        exp_t e;
        step();
        if (ack_en && (sd_rd || sd_wr)) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_req", {30'd0, sd_rd, sd_wr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("req_dir", {30'd0, sd_rd, sd_wr}, {30'd0, e.dir});
                check_val("req_lba", sd_lba, e.lba);
            end
            repeat (2) step();
            sd_ack = 1'b1;
            step();
            check_val("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
            repeat (2) step();
            sd_ack = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1; cart_download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        img_size_nz = 1'b0; osd_status = 1'b0; load_req = 1'b0; save_req = 1'b0;
        autosave_en = 1'b0; nvram_we = 1'b0; sd_ack = 1'b0;
        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        step();

        // Auto-load after a download with a writable image mounted.
        cart_download = 1'b1; img_size_nz = 1'b1;
        step();
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        check_val("ena_set", {31'd0, bk_ena}, 32'd1);
        push_xfer(DIR_RD);
        cart_download = 1'b0;
        step();
        check_val("autoload_loading", {31'd0, bk_loading}, 32'd1);
        check_val("autoload_rd", {31'd0, sd_rd}, 32'd1);
        wait_idle("autoload_done");
        check_val("autoload_end_loading", {31'd0, bk_loading}, 32'd0);
        check_val("autoload_last_lba", sd_lba, 32'd63);
        check_val("autoload_sb_empty", exp_q.size(), 32'd0);

        // Manual save.
        push_xfer(DIR_WR);
        save_req = 1'b1;
        step();
        check_val("save_busy", {31'd0, bk_busy}, 32'd1);
        check_val("save_wr", {30'd0, sd_rd, sd_wr}, 32'd1);
        wait_idle("save_done");
        check_val("save_last_lba", sd_lba, 32'd63);
        check_val("save_sb_empty", exp_q.size(), 32'd0);
        save_req = 1'b0;
        step();

        // Pending write then autosave on OSD open.
        nvram_we = 1'b1;
        step();
        nvram_we = 1'b0;
        check_val("pending_set", {31'd0, bk_pending}, 32'd1);
        autosave_en = 1'b1;
        push_xfer(DIR_WR);
        osd_status = 1'b1;
        step();
        check_val("autosave_busy", {31'd0, bk_busy}, 32'd1);
        check_val("autosave_wr", {31'd0, sd_wr}, 32'd1);
        step();
        check_val("pending_clear", {31'd0, bk_pending}, 32'd0);
        wait_idle("autosave_done");
        check_val("autosave_sb_empty", exp_q.size(), 32'd0);
        osd_status = 1'b0; autosave_en = 1'b0;
        step();

        // Coincident load and save edges, then a save edge while busy.
        push_xfer(DIR_RD);
        load_req = 1'b1; save_req = 1'b1;
        step();
        check_val("both_loading", {31'd0, bk_loading}, 32'd1);
        repeat (20) step();
        save_req = 1'b0;
        step();
        save_req = 1'b1;
        wait_idle("both_done");
        check_val("both_sb_empty", exp_q.size(), 32'd0);
        repeat (3) step();
        check_val("busy_save_dropped", {31'd0, bk_busy}, 32'd0);
        load_req = 1'b0; save_req = 1'b0;
        step();

        // Acknowledge never arrives: abort after 100 cycles.
        ack_en = 1'b0;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check_val("to_rd", {31'd0, sd_rd}, 32'd1);
        repeat (99) step();
        check_val("to_still_busy", {30'd0, bk_busy, bk_error}, 32'd2);
        step();
        check_val("to_error", {31'd0, bk_error}, 32'd1);
        check_val("to_rd_drop", {31'd0, sd_rd}, 32'd0);
        check_val("to_busy", {30'd0, bk_busy, bk_loading}, 32'd0);
        ack_en = 1'b1;
        step();

        // Reset while transferring sector 5.
        push_xfer(DIR_RD);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check_val("restart_clears_error", {31'd0, bk_error}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step();
            if (sd_lba == 32'd5 && sd_rd) found = 1'b1;
        end
        check_val("reach_sector5", {31'd0, found}, 32'd1);
        reset = 1'b1;
        step();
        check_outputs_zero("midreset");
        reset = 1'b0;
        repeat (10) step();
        exp_q.delete();

        // Read-only image: no transfers at all.
        cart_download = 1'b1; img_readonly = 1'b1;
        step();
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0; cart_download = 1'b0;
        repeat (2) step();
        check_val("ro_ena", {31'd0, bk_ena}, 32'd0);
        load_req = 1'b1;
        repeat (2) step();
        check_val("ro_load", {29'd0, bk_busy, sd_rd, sd_wr}, 32'd0);
        save_req = 1'b1;
        repeat (2) step();
        check_val("ro_save", {29'd0, bk_busy, sd_rd, sd_wr}, 32'd0);
        load_req = 1'b0; save_req = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
